// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: requester ports, shared results and controller command bus of the arbiter
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              p0_req, p1_req, p2_req;
  logic              p0_wr, p1_wr, p2_wr;
  logic [ADDR_W-1:0] p0_addr, p1_addr, p2_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p2_wdata;
  logic [1:0]        p0_dqm, p1_dqm, p2_dqm;
  logic              p0_ack, p1_ack, p2_ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [2:0]        grant;
  logic              ctl_req, ctl_wr;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic [1:0]        ctl_dqm;
  logic              ctl_ack, ctl_rvalid;
  logic [DATA_W-1:0] ctl_rdata;
  modport slave (
    input  p0_req, p1_req, p2_req, p0_wr, p1_wr, p2_wr,
    input  p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
    input  p0_dqm, p1_dqm, p2_dqm, ctl_ack, ctl_rvalid, ctl_rdata,
    output p0_ack, p1_ack, p2_ack, rdata, err, grant,
    output ctl_req, ctl_wr, ctl_addr, ctl_wdata, ctl_dqm
  );
  modport master (
    output p0_req, p1_req, p2_req, p0_wr, p1_wr, p2_wr,
    output p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
    output p0_dqm, p1_dqm, p2_dqm, ctl_ack, ctl_rvalid, ctl_rdata,
    input  p0_ack, p1_ack, p2_ack, rdata, err, grant,
    input  ctl_req, ctl_wr, ctl_addr, ctl_wdata, ctl_dqm
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: three-port SDRAM arbiter, port 0 absolute priority, ports 1/2 round-robin, read timeout
module dram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  dram_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DATA} state_t;
  state_t            state, state_d;
  logic [2:0]        grant_q, grant_d, ack_q, ack_d, req, win;
  logic              err_q, err_d, last2, last2_d, fin;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ctl_req_q, ctl_req_d, ctl_wr_q, ctl_wr_d;
  logic [ADDR_W-1:0] ctl_addr_q, ctl_addr_d;
  logic [DATA_W-1:0] ctl_wdata_q, ctl_wdata_d;
  logic [1:0]        ctl_dqm_q, ctl_dqm_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_dqm;
  // a port whose ack is showing this cycle has not yet had a chance to drop its request
  assign req     = {bus.p2_req, bus.p1_req, bus.p0_req} & ~ack_q;
  assign win     = req[0] ? 3'b001 :
                   (req[1] && req[2]) ? (last2 ? 3'b010 : 3'b100) :
                   req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
  assign w_wr    = win[0] ? bus.p0_wr    : win[1] ? bus.p1_wr    : bus.p2_wr;
  assign w_addr  = win[0] ? bus.p0_addr  : win[1] ? bus.p1_addr  : bus.p2_addr;
  assign w_wdata = win[0] ? bus.p0_wdata : win[1] ? bus.p1_wdata : bus.p2_wdata;
  assign w_dqm   = win[0] ? bus.p0_dqm   : win[1] ? bus.p1_dqm   : bus.p2_dqm;
  // next-state and next-output computation for the whole arbiter
  always_comb begin
    state_d     = state;
    grant_d     = grant_q;
    ack_d       = 3'b000;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    ctl_req_d   = ctl_req_q;
    ctl_wr_d    = ctl_wr_q;
    ctl_addr_d  = ctl_addr_q;
    ctl_wdata_d = ctl_wdata_q;
    ctl_dqm_d   = ctl_dqm_q;
    cnt_d       = cnt;
    last2_d     = last2;
    fin         = 1'b0;
    case (state)
      IDLE: if (|win) begin
        state_d     = GRANT;
        grant_d     = win;
        ctl_req_d   = 1'b1;
        ctl_wr_d    = w_wr;
        ctl_addr_d  = w_addr;
        ctl_wdata_d = w_wdata;
        ctl_dqm_d   = w_dqm;
      end
      GRANT: if (bus.ctl_ack) begin
        ctl_req_d = 1'b0;
        fin       = ctl_wr_q;
        state_d   = ctl_wr_q ? state : WAIT_DATA;
        cnt_d     = '0;
      end
      WAIT_DATA: begin
        cnt_d = cnt + CW'(1);
        if (bus.ctl_rvalid) begin
          rdata_d = bus.ctl_rdata;
          fin     = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          fin   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      ack_d   = grant_q;
      grant_d = 3'b000;
      last2_d = grant_q[0] ? last2 : grant_q[2];
    end
  end
  // state and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_q     <= 3'b000;
      ack_q       <= 3'b000;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ctl_req_q   <= 1'b0;
      ctl_wr_q    <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      ctl_dqm_q   <= 2'b11;
      cnt         <= '0;
      last2       <= 1'b1;
    end else begin
      state       <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ctl_req_q   <= ctl_req_d;
      ctl_wr_q    <= ctl_wr_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_wdata_q <= ctl_wdata_d;
      ctl_dqm_q   <= ctl_dqm_d;
      cnt         <= cnt_d;
      last2       <= last2_d;
    end
  end
  assign bus.p0_ack    = ack_q[0];
  assign bus.p1_ack    = ack_q[1];
  assign bus.p2_ack    = ack_q[2];
  assign bus.grant     = grant_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.ctl_req   = ctl_req_q;
  assign bus.ctl_wr    = ctl_wr_q;
  assign bus.ctl_addr  = ctl_addr_q;
  assign bus.ctl_wdata = ctl_wdata_q;
  assign bus.ctl_dqm   = ctl_dqm_q;
endmodule
